// File: rtl/coproc_pkg.sv
// Shared op-code, ASCII and encoder state definitions for the coprocessor host link.
// RESULT_ENCODER_ECHO_OP_EN adds the operator-echo states to the encoder state set.
package coproc_pkg;

    localparam logic [7:0] OP_ADD = 8'd1;
    localparam logic [7:0] OP_SUB = 8'd2;
    localparam logic [7:0] OP_MUL = 8'd3;
    localparam logic [7:0] OP_DIV = 8'd4;

    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_STAR  = 8'h2A;
    localparam logic [7:0] ASC_SLASH = 8'h2F;
    localparam logic [7:0] ASC_EQ    = 8'h3D;
    localparam logic [7:0] ASC_QUEST = 8'h3F;
    localparam logic [7:0] ASC_ZERO  = 8'h30;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
`ifdef RESULT_ENCODER_ECHO_OP_EN
        S_OP,
        S_EQ,
`endif
        S_SIGN,
        S_DIGITS,
        S_ERR,
        S_TERM
    } state_t;

    function automatic logic op_valid(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble: loads on start_i, shifts WIDTH times, pulses done_o with bcd_o valid.
module bin2bcd #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NDIG  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [WIDTH-1:0]  bin_i,
    output logic [NDIG*4-1:0] bcd_o,
    output logic              done_o
);

    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  sr_q;
    logic [NDIG*4-1:0] bcd_q, bcd_adj;
    logic [CNTW-1:0]   cnt_q;
    logic              run_q, done_q;

    // Add 3 to every digit >= 5 before the shift so it carries correctly into the next digit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            sr_q   <= bin_i;
            bcd_q  <= '0;
            cnt_q  <= CNTW'(WIDTH);
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            sr_q   <= {sr_q[WIDTH-2:0], 1'b0};
            bcd_q  <= {bcd_adj[NDIG*4-2:0], sr_q[WIDTH-1]};
            cnt_q  <= cnt_q - CNTW'(1);
            run_q  <= (cnt_q != CNTW'(1));
            done_q <= (cnt_q == CNTW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign bcd_o  = bcd_q;
    assign done_o = done_q;

endmodule

// File: rtl/result_encoder.sv
// Encodes an op code and signed result into an ASCII byte stream with valid/ack handshake.
// RESULT_ENCODER_ECHO_OP_EN: prefix the stream with the operator character and '='.
module result_encoder
    import coproc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter logic [7:0]  TERM  = 8'h0A
) (
    input  logic             i_clk,
    input  logic             reset,
    input  logic             i_ready,
    input  logic [7:0]       op_code,
    input  logic [WIDTH-1:0] result,
    input  logic             i_ack,
    output logic [7:0]       o_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error
);

    localparam int unsigned NDIG = (WIDTH * 30103 + 99999) / 100000;
    localparam int unsigned DIGW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t            state_q, state_d, nxt;
    logic [DIGW-1:0]   dig_q, dig_d, nxt_dig, msd;
    logic              neg_q, neg_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic              start_c, load, xfer;
    logic [3:0]        dsel;
    logic [WIDTH:0]    res_ext;
    logic [WIDTH-1:0]  mag_c;
    logic [NDIG*4-1:0] bcd;
    logic              bcd_done;
`ifdef RESULT_ENCODER_ECHO_OP_EN
    logic [7:0]        op_q, op_d;
`endif

    // Sign-extend before negating so the most negative input still yields its full magnitude.
    assign res_ext = {result[WIDTH-1], result};
    assign mag_c   = WIDTH'(result[WIDTH-1] ? -res_ext : res_ext);
    assign xfer    = valid_q && i_ack;

    bin2bcd #(.WIDTH(WIDTH), .NDIG(NDIG)) u_bin2bcd (
        .clk     (i_clk),
        .rst     (reset),
        .start_i (start_c),
        .bin_i   (mag_c),
        .bcd_o   (bcd),
        .done_o  (bcd_done)
    );

    // Most significant non-zero digit; zero magnitude falls back to the units digit.
    always_comb begin
        msd = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd[i*4 +: 4] != 4'd0) msd = DIGW'(i);
        end
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dig_q   <= '0;
            neg_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef RESULT_ENCODER_ECHO_OP_EN
            op_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            neg_q   <= neg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef RESULT_ENCODER_ECHO_OP_EN
            op_q    <= op_d;
`endif
        end
    end

    // Next state picks which byte to present next; load registers it with o_valid.
    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        neg_d   = neg_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        start_c = 1'b0;
        load    = 1'b0;
        nxt     = state_q;
        nxt_dig = dig_q;
        dsel    = 4'd0;
`ifdef RESULT_ENCODER_ECHO_OP_EN
        op_d    = op_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_ready) begin
                    busy_d = 1'b1;
                    neg_d  = result[WIDTH-1];
`ifdef RESULT_ENCODER_ECHO_OP_EN
                    op_d   = op_code;
`endif
                    if (op_valid(op_code)) begin
                        state_d = S_CONVERT;
                        start_c = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            S_CONVERT: begin
                if (bcd_done) begin
                    load = 1'b1;
`ifdef RESULT_ENCODER_ECHO_OP_EN
                    nxt  = S_OP;
`else
                    nxt     = neg_q ? S_SIGN : S_DIGITS;
                    nxt_dig = msd;
`endif
                end
            end
`ifdef RESULT_ENCODER_ECHO_OP_EN
            S_OP: begin
                if (xfer) begin
                    load = 1'b1;
                    nxt  = S_EQ;
                end
            end
            S_EQ: begin
                if (xfer) begin
                    load    = 1'b1;
                    nxt     = neg_q ? S_SIGN : S_DIGITS;
                    nxt_dig = msd;
                end
            end
`endif
            S_SIGN: begin
                if (xfer) begin
                    load    = 1'b1;
                    nxt     = S_DIGITS;
                    nxt_dig = msd;
                end
            end
            S_DIGITS: begin
                if (xfer) begin
                    load    = 1'b1;
                    nxt     = (dig_q == '0) ? S_TERM : S_DIGITS;
                    nxt_dig = (dig_q == '0) ? dig_q : dig_q - DIGW'(1);
                end
            end
            S_ERR: begin
                if (!valid_q || xfer) begin
                    load = 1'b1;
                    nxt  = valid_q ? S_TERM : S_ERR;
                end
            end
            S_TERM: begin
                if (xfer) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    data_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < int'(NDIG); i++) begin
            if (nxt_dig == DIGW'(i)) dsel = bcd[i*4 +: 4];
        end

        if (load) begin
            state_d = nxt;
            dig_d   = nxt_dig;
            valid_d = 1'b1;
            case (nxt)
`ifdef RESULT_ENCODER_ECHO_OP_EN
                S_OP: begin
                    case (op_q)
                        OP_ADD:  data_d = ASC_PLUS;
                        OP_SUB:  data_d = ASC_MINUS;
                        OP_MUL:  data_d = ASC_STAR;
                        default: data_d = ASC_SLASH;
                    endcase
                end
                S_EQ:     data_d = ASC_EQ;
`endif
                S_SIGN:   data_d = ASC_MINUS;
                S_DIGITS: data_d = ASC_ZERO + {4'd0, dsel};
                S_ERR:    data_d = ASC_QUEST;
                S_TERM:   data_d = TERM;
                default:  data_d = data_q;
            endcase
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_error = error_q;

endmodule

// File: tb/tb_result_encoder.sv
// Self-checking bench for result_encoder: expected bytes queued at stimulus, popped on each transfer.
// Honours RESULT_ENCODER_ECHO_OP_EN in the expected-stream model.
module tb_result_encoder;

    localparam int unsigned WIDTH = 16;
    localparam logic [7:0]  TERM  = 8'h0A;

    logic             i_clk = 1'b0;
    logic             reset, i_ready, i_ack;
    logic [7:0]       op_code;
    logic [WIDTH-1:0] result;
    logic [7:0]       o_data;
    logic             o_valid, o_busy, o_done, o_error;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];

    result_encoder #(.WIDTH(WIDTH), .TERM(TERM)) dut (
        .i_clk   (i_clk),
        .reset   (reset),
        .i_ready (i_ready),
        .op_code (op_code),
        .result  (result),
        .i_ack   (i_ack),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_error (o_error)
    );

    always #5 i_clk = ~i_clk;

    // Reference stream built from the decimal string of the magnitude.
    function automatic void push_expected(input logic [7:0] op, input int res);
        string s;
        int    mag;
        if (op < 8'd1 || op > 8'd4) begin
            exp_q.push_back(8'h3F);
            exp_q.push_back(TERM);
            return;
        end
`ifdef RESULT_ENCODER_ECHO_OP_EN
        case (op)
            8'd1:    exp_q.push_back(8'h2B);
            8'd2:    exp_q.push_back(8'h2D);
            8'd3:    exp_q.push_back(8'h2A);
            default: exp_q.push_back(8'h2F);
        endcase
        exp_q.push_back(8'h3D);
`endif
        if (res < 0) exp_q.push_back(8'h2D);
        mag = (res < 0) ? -res : res;
        s = $sformatf("%0d", mag);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
        exp_q.push_back(TERM);
    endfunction

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic start_op(input string name, input logic [7:0] op, input int res);
        logic inval;
        inval   = (op < 8'd1 || op > 8'd4);
        push_expected(op, res);
        i_ready = 1'b1;
        op_code = op;
        result  = WIDTH'(res);
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy: got %b want 1", name, o_busy);
        end
        checks++;
        if (o_error !== inval) begin
            errors++;
            $display("FAIL %s error_pulse: got %b want %b", name, o_error, inval);
        end
    endtask

    task automatic drain(input string name, input int exp_first, input int stall_byte,
                         input int stall_cycles, input bit poke);
        int         n_exp, exp_done, e, nbytes, stall, first;
        bit         got_done, err_seen;
        logic [7:0] held, exp_b;
        logic       ack;
        n_exp    = exp_q.size();
        exp_done = exp_first + n_exp + stall_cycles;
        e = 0; nbytes = 0; stall = 0; first = -1;
        got_done = 1'b0; err_seen = 1'b0; held = 8'h00;
        while (e < 200 && !got_done) begin
            if (o_done === 1'b1) begin
                got_done = 1'b1;
                checks++;
                if (e != exp_done) begin
                    errors++;
                    $display("FAIL %s done_latency: got %0d want %0d", name, e, exp_done);
                end
            end else begin
                if (e > 0 && o_error !== 1'b0) err_seen = 1'b1;
                if (o_valid === 1'b1 && first < 0) begin
                    first = e;
                    checks++;
                    if (first != exp_first) begin
                        errors++;
                        $display("FAIL %s first_valid: got %0d want %0d", name, first, exp_first);
                    end
                end
                ack = 1'b1;
                if (o_valid === 1'b1 && nbytes == stall_byte && stall < stall_cycles) begin
                    if (stall > 0) begin
                        checks++;
                        if (o_data !== held) begin
                            errors++;
                            $display("FAIL %s hold_stable: got %h want %h", name, o_data, held);
                        end
                    end
                    held  = o_data;
                    stall++;
                    ack   = 1'b0;
                end
                i_ack   = ack;
                i_ready = poke && (e == 4);
                if (poke && e == 4) begin
                    op_code = 8'd1;
                    result  = WIDTH'(5);
                end
                if (o_valid === 1'b1 && ack) begin
                    nbytes++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s extra_byte: got %h want none", name, o_data);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (o_data !== exp_b) begin
                            errors++;
                            $display("FAIL %s byte%0d: got %h want %h", name, nbytes - 1, o_data, exp_b);
                        end
                    end
                end
                @(posedge i_clk);
                @(negedge i_clk);
                e++;
            end
        end
        i_ready = 1'b0;
        i_ack   = 1'b1;
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL %s timeout: got no done want done", name);
        end
        checks++;
        if (exp_q.size() != 0 || err_seen) begin
            errors++;
            $display("FAIL %s leftover: got %0d missing bytes, stray error %b want 0, 0",
                     name, exp_q.size(), err_seen);
        end
        exp_q.delete();
    endtask

    task automatic check_idle(input string name);
        @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if ({o_done, o_busy, o_valid} !== 3'b000) begin
            errors++;
            $display("FAIL %s idle: got done/busy/valid %b want 000", name, {o_done, o_busy, o_valid});
        end
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_busy, o_valid} !== 2'b00) begin
            errors++;
            $display("FAIL %s stays_idle: got busy/valid %b want 00", name, {o_busy, o_valid});
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        i_ready = 1'b0;
        i_ack   = 1'b1;
        op_code = 8'd0;
        result  = '0;
        #1;
        checks++;
        if ({o_data, o_valid, o_busy, o_done, o_error} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got %h/%b%b%b%b want 00/0000",
                     o_data, o_valid, o_busy, o_done, o_error);
        end
        repeat (2) @(negedge i_clk);
        reset = 1'b0;
    endtask

    task automatic test_zero();
        start_op("zero", 8'd1, 0);
        drain("zero", WIDTH + 1, -1, 0, 1'b0);
        check_idle("zero");
    endtask

    task automatic test_negative();
        start_op("neg123", 8'd2, -123);
        drain("neg123", WIDTH + 1, -1, 0, 1'b0);
    endtask

    task automatic test_min();
        start_op("min", 8'd3, -32768);
        drain("min", WIDTH + 1, -1, 0, 1'b0);
    endtask

    task automatic test_stall();
        start_op("stall", 8'd4, 1000);
        drain("stall", WIDTH + 1, 1, 5, 1'b1);
        check_idle("stall");
    endtask

    task automatic test_error();
        start_op("badop", 8'd7, 55);
        drain("badop", 1, -1, 0, 1'b0);
        check_idle("badop");
    endtask

    // i_ready asserted in the o_done cycle must start the next stream.
    task automatic test_back_to_back();
        start_op("b2b_a", 8'd1, 7);
        drain("b2b_a", WIDTH + 1, -1, 0, 1'b0);
        start_op("b2b_b", 8'd3, 999);
        drain("b2b_b", WIDTH + 1, -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        push_expected(8'd2, -123);
        i_ready = 1'b1;
        op_code = 8'd2;
        result  = WIDTH'(-123);
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (o_valid === 1'b1 && o_data === 8'h32) begin
                found = 1'b1;
            end else begin
                if (o_valid === 1'b1) void'(exp_q.pop_front());
                @(posedge i_clk);
                @(negedge i_clk);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_mid reach_digits: got no '2' byte want one");
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({o_data, o_valid, o_busy, o_done, o_error} !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid async_clear: got %h/%b%b%b%b want 00/0000",
                     o_data, o_valid, o_busy, o_done, o_error);
        end
        exp_q.delete();
        @(negedge i_clk);
        reset = 1'b0;
        @(negedge i_clk);
        start_op("after_rst", 8'd1, 42);
        drain("after_rst", WIDTH + 1, -1, 0, 1'b0);
        check_idle("after_rst");
    endtask

    initial begin
        test_reset();
        test_zero();
        test_negative();
        test_min();
        test_stall();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_encoder.md
# result_encoder

Transmit-side counterpart of the operator decoder: takes an internal op code plus a signed binary result from the arithmetic core and encodes it back into an ASCII byte stream for the host link. The stream is the signed decimal result, optionally prefixed by the operator echo, and always terminated by a line terminator. It sits between the ALU result path and the UART transmitter. Each byte is handed over with a valid/ack handshake.

## Interface
- WIDTH, 16: result width, two's complement.
- TERM, 8'h0A: terminator byte.
- i_clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_ready  in  1  start pulse; samples `op_code` and `result`; honoured only in IDLE.
- op_code  in  8  1 = '+', 2 = '-', 3 = '*', 4 = '/'; any other value is invalid.
- result  in  WIDTH  signed result to encode.
- i_ack  in  1  downstream accepts `o_data` this cycle.
- o_data  out  8  ASCII byte; reset value 0.
- o_valid  out  1  `o_data` is valid; reset value 0.
- o_busy  out  1  high from capture until the terminator is accepted; reset value 0.
- o_done  out  1  one-cycle pulse after the terminator is accepted; reset value 0.
- o_error  out  1  one-cycle pulse on capture of an invalid `op_code`; reset value 0.

## Operation
- States and transitions:
  - IDLE → CONVERT on `i_ready`.
  - CONVERT → OP (macro on) or SIGN (macro off).
  - OP → EQ → SIGN → DIGITS → TERM → IDLE.
  - Invalid op: IDLE → ERR → TERM.
- Capture:
  - Latch `op_code`.
  - Magnitude = |result|, computed in WIDTH+1 bits, so the most negative value (-32768 at WIDTH=16) encodes correctly.
  - Latch the sign.
- CONVERT: shift-add-3 binary-to-BCD over exactly WIDTH cycles. NDIG = ceil(WIDTH·log10 2) digits (5 at WIDTH=16).
- SIGN: emits '-' (8'h2D) only if the result is negative; otherwise skipped with no bubble cycle.
- DIGITS:
  - Emits digits MSD first as 8'h30+d.
  - Leading zeros suppressed.
  - Zero result emits a single '0'.
- ERR: emits '?' (8'h3F), followed by TERM. No digits are emitted.
- Handshake:
  - A byte transfers on a cycle where `o_valid && i_ack`.
  - `o_data` and `o_valid` are held stable until acknowledged.
  - The next byte is presented the cycle after the transfer, so sustained `i_ack` gives 1 byte/cycle.
- `i_ready` while `o_busy` is ignored; no queueing.
- `o_done` pulses the cycle after TERM transfers. `i_ready` in that same cycle is accepted.
- Reset mid-stream: all outputs go to 0 immediately, state returns to IDLE, and the partial stream is abandoned.

## Timing
- `i_ready` sampled at edge 0.
- `o_busy` high after edge 0.
- CONVERT occupies edges 1..WIDTH.
- First `o_valid` after edge WIDTH+1.
- Total latency with `i_ack` tied high: WIDTH+1+N_bytes+1 cycles to `o_done`.
- `o_error` is high for the single cycle after edge 0. An invalid op skips CONVERT, so '?' is valid after edge 1.

## Configuration
- `RESULT_ENCODER_ECHO_OP_EN` defined: OP emits the operator char ('+' 2B, '-' 2D, '*' 2A, '/' 2F), then EQ emits '=' (8'h3D) before the sign/digits.
- Undefined: OP and EQ states do not exist; the stream is sign, digits, TERM only.

## Structure
- Shared package `coproc_pkg` holds:
  - op-code constants 1..4;
  - ASCII constants for + - * / = ? 0;
  - state encoding.
- Sub-module `bin2bcd`: sequential double-dabble with WIDTH/NDIG parameters, start/done ports, and a packed BCD output.
- The FSM and byte mux stay in `result_encoder`.

## Test plan
- op 1, result 0, ack high, macro on → bytes 2B 3D 30 0A; `o_done` one cycle; latency 16+1+4+1.
- op 2, result -123, macro off → 2D 31 32 33 0A.
- op 3, result -32768 → 2D 33 32 37 36 38 0A; no overflow artefacts.
- op 4, result 1000, `i_ack` low 5 cycles on the second byte → `o_data` held stable, no byte lost or duplicated; `i_ready` pulsed while busy is ignored.
- op 7 → `o_error` pulse the cycle after capture, stream 3F 0A, then `o_done`.
- Reset asserted asynchronously during DIGITS → outputs 0 without waiting for a clock edge; a fresh op 1, result 42 afterwards → clean stream (macro on: 2B 3D 34 32 0A).
